// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   en_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic             SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic             AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]       SEG_OFF   = SEG_INV ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_INV}};
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h7E;
            4'h1: hex_decode = 7'h30;
            4'h2: hex_decode = 7'h6D;
            4'h3: hex_decode = 7'h79;
            4'h4: hex_decode = 7'h33;
            4'h5: hex_decode = 7'h5B;
            4'h6: hex_decode = 7'h5F;
            4'h7: hex_decode = 7'h70;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h73;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h1F;
            4'hC: hex_decode = 7'h4E;
            4'hD: hex_decode = 7'h3D;
            4'hE: hex_decode = 7'h4F;
            4'hF: hex_decode = 7'h47;
            default: hex_decode = 7'h00;
        endcase
    endfunction

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] pend_digits_r, act_digits_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r, pend_en_r, act_dp_r, act_en_r;
    logic                    pend_valid_r;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic                    wrap_s, boundary_s;
    logic [0:0]              slot_state_s;
    logic [3:0]              nib_s;
    logic                    dp_sel_s;
    logic [NUM_DIGITS-1:0]   an_sel_s;
    logic [6:0]              seg_s;
    logic                    dp_s;
    logic [NUM_DIGITS-1:0]   an_s;

    assign wrap_s       = (cnt_r == CNT_LAST);
    assign boundary_s   = wrap_s && (idx_r == IDX_LAST);
    assign slot_state_s = (cnt_r < CNT_BLANK) ? ST_BLANK : ST_ON;

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Pending/active buffers; active only changes at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_digits_r <= '0;
            pend_dp_r     <= '0;
            pend_en_r     <= '0;
            pend_valid_r  <= 1'b0;
            act_digits_r  <= '0;
            act_dp_r      <= '0;
            act_en_r      <= '0;
        end else if (boundary_s) begin
            pend_valid_r <= 1'b0;
            if (load_i) begin
                act_digits_r <= digits_i;
                act_dp_r     <= dp_i;
                act_en_r     <= en_i;
            end else if (pend_valid_r) begin
                act_digits_r <= pend_digits_r;
                act_dp_r     <= pend_dp_r;
                act_en_r     <= pend_en_r;
            end else begin
                act_digits_r <= act_digits_r;
            end
        end else if (load_i) begin
            pend_digits_r <= digits_i;
            pend_dp_r     <= dp_i;
            pend_en_r     <= en_i;
            pend_valid_r  <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

`ifdef SSD_LZB_EN
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic lead;
        lead    = 1'b1;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (d[4*k +: 4] != 4'h0) begin
                lead = 1'b0;
            end else begin
                lead = lead;
            end
            lz_mask[k] = lead;
        end
    endfunction

    logic [NUM_DIGITS-1:0] blank_r;

    // Leading-zero mask follows whatever data becomes active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_r <= '0;
        end else if (boundary_s && load_i) begin
            blank_r <= lz_mask(digits_i);
        end else if (boundary_s && pend_valid_r) begin
            blank_r <= lz_mask(pend_digits_r);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign blank_s = blank_r;
`else
    assign blank_s = '0;
`endif

    // Select the current digit and form next output values
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        an_sel_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                nib_s       = act_digits_r[4*k +: 4];
                dp_sel_s    = act_dp_r[k];
                an_sel_s[k] = act_en_r[k] & ~blank_s[k];
            end else begin
                an_sel_s[k] = 1'b0;
            end
        end
        case (slot_state_s)
            ST_ON: begin
                seg_s = SEG_INV ? ~hex_decode(nib_s) : hex_decode(nib_s);
                dp_s  = dp_sel_s ^ SEG_INV;
                an_s  = AN_INV ? ~an_sel_s : an_sel_s;
            end
            default: begin
                seg_s = SEG_OFF;
                dp_s  = SEG_INV;
                an_s  = AN_OFF;
            end
        endcase
    end

    // Registered pin outputs, one cycle behind the scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= SEG_OFF;
            dp_o    <= SEG_INV;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_s;
            dp_o    <= dp_s;
            an_o    <= an_s;
            frame_o <= boundary_s;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (4 digits, 8-cycle slots, 2-cycle dead time, active-low).
module tb_ssd_scan_driver;
    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = N * R;
    localparam logic [6:0] DEC [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i, en_i;
    logic        load_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .en_i(en_i),
        .load_i(load_i), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
    );

    int tests = 0;
    int fails = 0;
    int c;
    int act_d [N];
    bit act_dp [N];
    bit act_en [N];
    int pen_d [N];
    bit pen_dp [N];
    bit pen_en [N];
    bit pend;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;
    logic       exp_frame;

    function automatic bit lz_dark(int k);
`ifdef SSD_LZB_EN
        if (k == 0) return 1'b0;
        for (int j = k; j < N; j++) if (act_d[j] != 0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        c = 0;
        pend = 1'b0;
        for (int k = 0; k < N; k++) begin
            act_d[k] = 0; act_dp[k] = 1'b0; act_en[k] = 1'b0;
            pen_d[k] = 0; pen_dp[k] = 1'b0; pen_en[k] = 1'b0;
        end
    endtask

    // One clock: predict from the model, advance the model, compare after the edge
    task automatic cyc();
        int slot, off;
        slot = (c / R) % N;
        off  = c % R;
        exp_frame = ((c % F) == F - 1);
        if (off < B) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            exp_seg = ~DEC[act_d[slot]];
            exp_dp  = ~act_dp[slot];
            exp_an  = 4'hF;
            if (act_en[slot] && !lz_dark(slot)) exp_an[slot] = 1'b0;
        end
        if ((c % F) == F - 1) begin
            if (load_i) begin
                for (int k = 0; k < N; k++) begin
                    act_d[k] = int'(digits_i[4*k +: 4]); act_dp[k] = dp_i[k]; act_en[k] = en_i[k];
                end
            end else if (pend) begin
                for (int k = 0; k < N; k++) begin
                    act_d[k] = pen_d[k]; act_dp[k] = pen_dp[k]; act_en[k] = pen_en[k];
                end
            end
            pend = 1'b0;
        end else if (load_i) begin
            for (int k = 0; k < N; k++) begin
                pen_d[k] = int'(digits_i[4*k +: 4]); pen_dp[k] = dp_i[k]; pen_en[k] = en_i[k];
            end
            pend = 1'b1;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({an_o, seg_o, dp_o, frame_o} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
            fails++;
            $display("FAIL scan c=%0d an=%h exp %h seg=%h exp %h dp=%b exp %b frame=%b exp %b",
                     c, an_o, exp_an, seg_o, exp_seg, dp_o, exp_dp, frame_o, exp_frame);
        end
        c++;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        digits_i = d; dp_i = dp; en_i = en; load_i = 1'b1;
        cyc();
        load_i = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic align_to(input int phase);
        while ((c % F) != phase) cyc();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({an_o, seg_o, dp_o, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_async an=%h seg=%h dp=%b frame=%b exp F/7F/1/0", an_o, seg_o, dp_o, frame_o);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(F + 5);
    endtask

    task automatic test_load_basic();
        do_load(16'h1234, 4'h0, 4'hF);
        for (int i = 0; i < 2 * F; i++) begin
            cyc();
            if (an_o == 4'b1110) begin
                tests++;
                if (seg_o !== 7'h4C) begin
                    fails++; $display("FAIL load_digit0 seg=%h exp 4C", seg_o);
                end
            end
            if (an_o == 4'b0111) begin
                tests++;
                if (seg_o !== 7'h4F) begin
                    fails++; $display("FAIL load_digit3 seg=%h exp 4F", seg_o);
                end
            end
        end
    endtask

    task automatic test_refresh();
        int last, seen;
        last = -1; seen = 0;
        for (int i = 0; i < 3 * F + 2; i++) begin
            cyc();
            if (frame_o) begin
                if (last >= 0) begin
                    tests++;
                    if (c - last != F) begin
                        fails++; $display("FAIL frame_period got %0d exp %0d", c - last, F);
                    end
                end
                last = c; seen++;
            end
        end
        tests++;
        if (seen < 3) begin
            fails++; $display("FAIL frame_count got %0d exp >=3", seen);
        end
    endtask

    task automatic test_midframe_reload();
        align_to(15);
        do_load(16'hABCD, 4'h0, 4'hF);
        run(F);
        for (int i = 0; i < F; i++) begin
            cyc();
            if (an_o == 4'b1110) begin
                tests++;
                if (seg_o !== 7'h42) begin
                    fails++; $display("FAIL reload_digit0 seg=%h exp 42", seg_o);
                end
            end
        end
    endtask

    task automatic test_enable_dp();
        do_load(16'h5A3C, 4'b0001, 4'b0101);
        run(3 * F);
    endtask

    task automatic test_lzb();
        do_load(16'h0040, 4'h0, 4'hF);
        run(2 * F);
        do_load(16'h0000, 4'h0, 4'hF);
        run(2 * F);
    endtask

    task automatic test_back_to_back();
        do_load(16'h1111, 4'h1, 4'hF);
        align_to(F - 1);
        do_load(16'h5678, 4'h2, 4'hF);
        run(F + 3);
        align_to(F - 2);
        do_load(16'h9ABC, 4'h4, 4'hE);
        run(4);
        do_load(16'h2222, 4'h0, 4'hF);
        do_load(16'h3333, 4'h0, 4'hF);
        do_load(16'hDEF0, 4'h8, 4'hB);
        run(2 * F);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8 * F; i++) begin
            if ($urandom_range(0, 19) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            else
                cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0; load_i = 1'b0; digits_i = 16'h0; dp_i = 4'h0; en_i = 4'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_basic();
        test_refresh();
        test_midframe_reload();
        test_enable_dp();
        test_lzb();
        test_back_to_back();
        test_random();
        run(13);
        test_reset();
        test_load_basic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
